// File: rtl/vga_sync_generator.sv
// VGA raster timing source for the TinyQV VGA peripheral.
// Produces x/y counters plus registered hsync, vsync, blank and a per-line
// retrace strobe, and owns the peripheral's sticky interrupt. Each output is
// registered from the next-state counter values, so it describes the same
// x/y that appears alongside it. The two mode inputs are latched only at the
// frame wrap, so a frame never changes geometry part-way through.
module vga_sync_generator #(
  parameter int H_TOTAL         = 1344,
  parameter int H_ACTIVE_WIDE   = 1024,
  parameter int H_ACTIVE_NARROW = 960,
  parameter int H_FRONT_WIDE    = 24,
  parameter int H_FRONT_NARROW  = 56,
  parameter int H_SYNC_WIDTH    = 136,
  parameter int V_VISIBLE       = 768,
  parameter int V_FRONT         = 3,
  parameter int V_SYNC_LINES    = 6,
  parameter int V_TOTAL_LONG    = 804,
  parameter int V_TOTAL_SHORT   = 798
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cli,
  input  logic        ei_hblank,
  input  logic        ei_vblank,
  input  logic        narrow_960,
  input  logic        clk_63_5mhz,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        retrace,
  output logic        blank,
  output logic        interrupt
);

  localparam logic [10:0] X_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] ACT_WIDE    = 11'(H_ACTIVE_WIDE);
  localparam logic [10:0] ACT_NARROW  = 11'(H_ACTIVE_NARROW);
  localparam logic [10:0] HS_BEG_WIDE = 11'(H_ACTIVE_WIDE + H_FRONT_WIDE);
  localparam logic [10:0] HS_END_WIDE = 11'(H_ACTIVE_WIDE + H_FRONT_WIDE + H_SYNC_WIDTH);
  localparam logic [10:0] HS_BEG_NAR  = 11'(H_ACTIVE_NARROW + H_FRONT_NARROW);
  localparam logic [10:0] HS_END_NAR  = 11'(H_ACTIVE_NARROW + H_FRONT_NARROW + H_SYNC_WIDTH);
  localparam logic [9:0]  Y_VIS       = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_BEG      = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END      = 10'(V_VISIBLE + V_FRONT + V_SYNC_LINES);
  localparam logic [9:0]  Y_LAST_LONG = 10'(V_TOTAL_LONG - 1);
  localparam logic [9:0]  Y_LAST_SHORT = 10'(V_TOTAL_SHORT - 1);

  logic        narrow_q;
  logic        short_q;

  logic        x_wrap;
  logic        frame_wrap;
  logic [9:0]  y_last;
  logic [10:0] x_next;
  logic [9:0]  y_next;
  logic        narrow_next;
  logic        short_next;
  logic [10:0] act_next;
  logic [10:0] hs_beg_next;
  logic [10:0] hs_end_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        blank_next;
  logic        retrace_next;
  logic        set_h;
  logic        set_v;
  logic        interrupt_next;

  // Next counter values, the mode for the upcoming cycle, and every output derived from them
  always_comb begin
    x_wrap         = (x == X_LAST);
    y_last         = short_q ? Y_LAST_SHORT : Y_LAST_LONG;
    frame_wrap     = x_wrap && (y == y_last);
    x_next         = x_wrap ? 11'd0 : x + 11'd1;
    y_next         = y;
    if (x_wrap) begin
      y_next = (y == y_last) ? 10'd0 : y + 10'd1;
    end
    narrow_next    = frame_wrap ? narrow_960 : narrow_q;
    short_next     = frame_wrap ? clk_63_5mhz : short_q;
    act_next       = narrow_next ? ACT_NARROW : ACT_WIDE;
    hs_beg_next    = narrow_next ? HS_BEG_NAR : HS_BEG_WIDE;
    hs_end_next    = narrow_next ? HS_END_NAR : HS_END_WIDE;
    hsync_next     = !((x_next >= hs_beg_next) && (x_next < hs_end_next));
    vsync_next     = !((y_next >= VS_BEG) && (y_next < VS_END));
    blank_next     = (x_next >= act_next) || (y_next >= Y_VIS);
    retrace_next   = (x_next == act_next) && (y_next < Y_VIS);
    set_h          = ei_hblank && retrace;
    set_v          = ei_vblank && (x == 11'd0) && (y == Y_VIS);
    interrupt_next = (interrupt && !cli) || set_h || set_v;
  end

  // Timing state register; reset parks the raster at the top-left of a wide, long frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= 11'd0;
      y         <= 10'd0;
      narrow_q  <= 1'b0;
      short_q   <= 1'b0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      blank     <= 1'b0;
      retrace   <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      x         <= x_next;
      y         <= y_next;
      narrow_q  <= narrow_next;
      short_q   <= short_next;
      hsync     <= hsync_next;
      vsync     <= vsync_next;
      blank     <= blank_next;
      retrace   <= retrace_next;
      interrupt <= interrupt_next;
    end
  end

endmodule
